mb_sequencer: RTL and testbench

Macroblock sequencer that drives the intra predictor: walks a frame in raster order, issues one macroblock number at a time over a valid/ready handshake, and waits for the predictor's completion pulse before issuing the next. Alongside each number it supplies decoded MB coordinates and neighbour-availability flags for the prediction mode logic. It sits ahead of `intrapred` and replaces free-running `mbnumber` stepping with flow-controlled sequencing.

---
 rtl/mb_sequencer.sv | 119 +++++++++++
 tb/tb_mb_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mb_sequencer.sv
// Raster-order macroblock sequencer for the intra predictor: offers one MB number
// per valid/ready transfer, then waits for pred_done before moving on.
module mb_sequencer #(
  parameter int MB_WIDTH  = 120,
  parameter int MB_HEIGHT = 68
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        pred_ready,
  input  logic        pred_done,
  output logic [12:0] mbnumber,
  output logic        mb_valid,
  output logic [7:0]  mb_x,
  output logic [7:0]  mb_y,
  output logic        avail_left,
  output logic        avail_top,
  output logic        avail_topleft,
  output logic        avail_topright,
  output logic        last_mb,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [7:0]  XLAST  = 8'(MB_WIDTH - 1);
  localparam logic [12:0] MBLAST = 13'(MB_WIDTH * MB_HEIGHT - 1);

  if (MB_WIDTH < 1 || MB_WIDTH > 255 || MB_HEIGHT < 1 || MB_HEIGHT > 255 ||
      MB_WIDTH * MB_HEIGHT > 8192) begin : g_bad_geometry
    $error("mb_sequencer: unsupported frame geometry");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [12:0] num_reg, num_next;
  logic [7:0]  x_reg, x_next;
  logic [7:0]  y_reg, y_next;
  // Keeps last_mb low out of reset even when the frame is a single MB.
  logic        seen_reg, seen_next;
  logic        is_last;

  assign is_last = (num_reg == MBLAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      num_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      seen_reg  <= 1'b0;
    end else if (enable) begin
      state_reg <= state_next;
      num_reg   <= num_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      seen_reg  <= seen_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    num_next   = num_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    seen_next  = seen_reg;
    mb_valid   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          num_next   = '0;
          x_next     = '0;
          y_next     = '0;
          seen_next  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mb_valid = 1'b1;
        if (pred_ready) state_next = WAIT;
      end
      WAIT: begin
        if (pred_done) begin
          if (is_last) begin
            state_next = DONE;
          end else begin
            num_next   = num_reg + 13'd1;
            state_next = ISSUE;
            if (x_reg == XLAST) begin
              x_next = '0;
              y_next = y_reg + 8'd1;
            end else begin
              x_next = x_reg + 8'd1;
            end
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mbnumber       = num_reg;
  assign mb_x           = x_reg;
  assign mb_y           = y_reg;
  assign avail_left     = (x_reg != 8'd0);
  assign avail_top      = (y_reg != 8'd0);
  assign avail_topleft  = (x_reg != 8'd0) && (y_reg != 8'd0);
  assign avail_topright = (y_reg != 8'd0) && (x_reg != XLAST);
  assign last_mb        = seen_reg && is_last;

endmodule

// File: tb/tb_mb_sequencer.sv
// Bench for mb_sequencer: a 4x3 and a 1x1 instance share stimulus and are both
// compared every cycle against an index-based reference model.
module tb_mb_sequencer;

  localparam int P_IDLE = 0, P_OFFER = 1, P_WAIT = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic reset, enable, start, pred_ready, pred_done;

  logic [12:0] num [2];
  logic [7:0]  mx [2];
  logic [7:0]  my [2];
  logic        valid [2], al [2], at [2], atl [2], atr [2], last [2], bsy [2], fdone [2];

  int ph [2];
  int ix [2];
  bit seen [2];
  int gw [2] = '{4, 1};
  int gh [2] = '{3, 1};

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int stall;

  always #5 clk = ~clk;

  mb_sequencer #(.MB_WIDTH(4), .MB_HEIGHT(3)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .pred_ready(pred_ready), .pred_done(pred_done),
    .mbnumber(num[0]), .mb_valid(valid[0]), .mb_x(mx[0]), .mb_y(my[0]),
    .avail_left(al[0]), .avail_top(at[0]), .avail_topleft(atl[0]),
    .avail_topright(atr[0]), .last_mb(last[0]), .busy(bsy[0]),
    .frame_done(fdone[0])
  );

  mb_sequencer #(.MB_WIDTH(1), .MB_HEIGHT(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .pred_ready(pred_ready), .pred_done(pred_done),
    .mbnumber(num[1]), .mb_valid(valid[1]), .mb_x(mx[1]), .mb_y(my[1]),
    .avail_left(al[1]), .avail_top(at[1]), .avail_topleft(atl[1]),
    .avail_topright(atr[1]), .last_mb(last[1]), .busy(bsy[1]),
    .frame_done(fdone[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ph[d] = P_IDLE;
      ix[d] = 0;
      seen[d] = 1'b0;
    end
  endtask

  // Expected outputs follow from the raster index alone.
  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int x;
      int y;
      string p;
      x = ix[d] % gw[d];
      y = ix[d] / gw[d];
      p = $sformatf("t=%0t dut%0d", $time, d);
      chk({p, " mbnumber"}, 32'(num[d]), ix[d]);
      chk({p, " mb_x"}, 32'(mx[d]), x);
      chk({p, " mb_y"}, 32'(my[d]), y);
      chk({p, " mb_valid"}, 32'(valid[d]), 32'(ph[d] == P_OFFER));
      chk({p, " busy"}, 32'(bsy[d]), 32'(ph[d] != P_IDLE));
      chk({p, " frame_done"}, 32'(fdone[d]), 32'(ph[d] == P_DONE));
      chk({p, " last_mb"}, 32'(last[d]), 32'(seen[d] && ix[d] == gw[d] * gh[d] - 1));
      chk({p, " avail_left"}, 32'(al[d]), 32'(x != 0));
      chk({p, " avail_top"}, 32'(at[d]), 32'(y != 0));
      chk({p, " avail_topleft"}, 32'(atl[d]), 32'(x != 0 && y != 0));
      chk({p, " avail_topright"}, 32'(atr[d]), 32'(y != 0 && x != gw[d] - 1));
    end
  endtask

  task automatic cyc(input bit s, input bit r, input bit dn, input bit e);
    start = s;
    pred_ready = r;
    pred_done = dn;
    enable = e;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (e) begin
        case (ph[d])
          P_IDLE: if (s) begin ix[d] = 0; ph[d] = P_OFFER; seen[d] = 1'b1; end
          P_OFFER: if (r) ph[d] = P_WAIT;
          P_WAIT: if (dn) begin
            if (ix[d] == gw[d] * gh[d] - 1) ph[d] = P_DONE;
            else begin ix[d]++; ph[d] = P_OFFER; end
          end
          default: ph[d] = P_IDLE;
        endcase
      end
    end
    #1;
    if (fdone[0] === 1'b1) fd_cnt++;
    check_all();
    $display("cyc t=%0t start=%0b rdy=%0b done=%0b en=%0b | mb0=%0d v0=%0b fd0=%0b | mb1=%0d v1=%0b fd1=%0b",
             $time, s, r, dn, e, num[0], valid[0], fdone[0], num[1], valid[1], fdone[1]);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    start = 1'b0;
    pred_ready = 1'b0;
    pred_done = 1'b0;
    model_reset();
    #12;
    check_all();
    reset = 1'b0;

    // Frame 1: backpressure, spurious start/done, freeze window.
    cyc(0, 1, 1, 1);
    cyc(1, 0, 0, 1);
    for (int mb = 0; mb < 12; mb++) begin
      stall = (mb == 2) ? 5 : (mb == 3) ? 2 : 0;
      for (int i = 0; i < stall; i++) cyc(mb == 3 && i == 0, 0, i == 1, 1);
      cyc(0, 1, mb == 8, 1);
      if (mb == 6) for (int i = 0; i < 4; i++) cyc(0, 0, i == 1, 0);
      if (mb == 4) cyc(1, 0, 0, 1);
      cyc(0, 0, 1, 1);
    end
    cyc(0, 0, 0, 1);
    chk("frame1 frame_done pulses", fd_cnt, 1);

    // Frame 2: asynchronous reset while MB 9 is offered.
    fd_cnt = 0;
    cyc(1, 0, 0, 1);
    for (int mb = 0; mb < 9; mb++) begin
      cyc(0, 1, 0, 1);
      cyc(0, 0, 1, 1);
    end
    chk("frame2 reached mb9", 32'(num[0]), 9);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    #1 reset = 1'b0;
    cyc(0, 1, 1, 1);
    cyc(1, 0, 0, 1);
    chk("restart mbnumber", 32'(num[0]), 0);
    chk("frame2 frame_done pulses", fd_cnt, 0);

    // Randomised traffic, still checked every cycle.
    repeat (600) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
